i2c_target_rx: RTL
==================

Name: i2c_target_rx

Overview:
- Write-only I2C target (slave) receiver. It is the responder for the codec-configuration I2C master.
- Watches SCL/SDA, detects START/STOP, and matches the 7-bit device address.
- Receives a 2-byte payload (register byte, then data byte) and ACKs each byte by pulling SDA low.
- Presents the assembled 16-bit word with a one-cycle valid strobe.
- Used as an on-chip loopback target and as an emulated peripheral for bring-up.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address this block acknowledges.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- scl_in  input  1  SCL line level (asynchronous to clk).
- sda_in  input  1  SDA line level (asynchronous to clk).
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release. Top level ties SDA to 1'bz when 0 and 1'b0 when 1.
- data_out  output  16  {register byte, data byte} of the last complete frame.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- busy  output  1  1 whenever state != IDLE.
- frame_err  output  1  one-cycle pulse when an address-matched frame is aborted before its data-byte ACK completes.

Behaviour:
- Reset (rst==0 at posedge clk): state=IDLE, sda_oe=0, data_out=16'h0000, data_valid=0, frame_err=0, bit_cnt=0, shift register=0, synchronizer flops=1.
- Synchronization: scl_in and sda_in each pass through a 2-flop synchronizer plus one history flop.
  - scl_rise = s & ~prev; scl_fall = ~s & prev.
  - Edge-to-action latency is 3 clk.
- SCL high and low phases are required to be >= 4 clk each.
- START: sda falls while synced SCL is high.
  - Valid in any state, including mid-byte (repeated START).
  - Forces state=ADDR, bit_cnt=0, sda_oe=0.
- STOP: sda rises while synced SCL is high.
  - Valid in any state; forces state=IDLE, sda_oe=0.
- START/STOP detection takes priority over SCL edge processing in the same cycle.
- Bit capture: on scl_rise in ADDR/REG/DATA, shift = {shift[6:0], sda}, MSB first, bit_cnt increments.
- States: IDLE, ADDR, ACK_ADDR, REG, ACK_REG, DATA, ACK_DATA, WAIT_STOP.
- Byte end: on the scl_fall following the 8th scl_rise (bit_cnt==8), move to ACK_x and clear bit_cnt.
  - ADDR byte: if shift[7:1]==DEV_ADDR and shift[0]==0 (write), set sda_oe=1 and go to ACK_ADDR.
  - ADDR byte otherwise (mismatch or read request): sda_oe stays 0 (NACK) and state goes to WAIT_STOP.
  - REG byte: latch reg_byte=shift and set sda_oe=1.
  - DATA byte: latch data_byte=shift and set sda_oe=1.
- ACK slot: sda_oe is held through the 9th SCL high phase. On the next scl_fall:
  - sda_oe=0.
  - ACK_ADDR -> REG; ACK_REG -> DATA; ACK_DATA -> WAIT_STOP.
  - Leaving ACK_DATA also sets data_out={reg_byte,data_byte} and data_valid=1 for exactly that one cycle.
- WAIT_STOP: ignores all SCL edges and never asserts sda_oe, so any further bytes are NACKed. Exits only on STOP (to IDLE) or START (to ADDR).
- frame_err pulses 1 cycle when START or STOP is detected while state is ACK_ADDR, REG, ACK_REG, DATA or ACK_DATA.
  - data_out is unchanged and data_valid is not asserted.
- IDLE ignores SCL edges and waits for START.
- sda_oe is never asserted outside the ACK_ADDR/ACK_REG/ACK_DATA states.
- Reset mid-transfer: sda_oe drops on the first reset cycle and no strobe is produced.
- busy is combinational from state.

Test Plan:
- Write frame: START, 0x34 (addr 0x1A, W), 0x1E, 0x05, STOP -> sda_oe asserted in all 3 ACK slots; data_out=16'h1E05; data_valid high exactly 1 clk; frame_err=0; busy=0 after STOP.
- Address mismatch: START, 0x36, 0x1E, 0x05, STOP -> sda_oe never 1; no data_valid; data_out keeps previous 16'h1E05; frame_err=0.
- Read request: START, 0x35 -> NACK (sda_oe=0 in the 9th clock); state WAIT_STOP; no data_valid.
- Aborted frame: START, 0x34, 0x1E, STOP -> two ACKs, frame_err pulses once, no data_valid.
- Repeated START mid-DATA after 4 bits, then full frame 0x34, 0xAA, 0x55, STOP -> exactly one data_valid with data_out=16'hAA55; one frame_err from the abort.
- Extra byte plus reset: frame 0x34, 0x01, 0x02, then a 4th byte 0xFF -> 4th byte NACKed, data_out=16'h0102. Then rst=0 for 1 clk while sda_oe=1 during the REG ACK of a new frame -> sda_oe=0 and data_out=0 on the next cycle.

Source files
------------

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: matches DEV_ADDR, receives {register, data} bytes,
// ACKs each byte and strobes the assembled 16-bit word.
module i2c_target_rx #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        REG,
        ACK_REG,
        DATA,
        ACK_DATA,
        WAIT_STOP
    } state_t;

    state_t      state_q;
    logic [1:0]  scl_sync_q;
    logic [1:0]  sda_sync_q;
    logic        scl_prev_q;
    logic        sda_prev_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  reg_q;
    logic [7:0]  data_q;
    logic        sda_oe_q;
    logic [15:0] data_out_q;
    logic        valid_q;
    logic        err_q;

    logic        scl_s;
    logic        sda_s;
    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;
    logic        addr_hit;
    logic        in_frame;
    logic [7:0]  shift_d;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev_q & sda_s;
    assign shift_d   = {shift_q[6:0], sda_s};
    assign addr_hit  = (shift_q[7:1] == DEV_ADDR) && !shift_q[0];

    // States in which an address-matched frame has not yet delivered its word
    assign in_frame = (state_q == ACK_ADDR) || (state_q == REG) ||
                      (state_q == ACK_REG)  || (state_q == DATA) ||
                      (state_q == ACK_DATA);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            reg_q      <= '0;
            data_q     <= '0;
            sda_oe_q   <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;

            if (start_det || stop_det) begin
                err_q     <= in_frame;
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= start_det ? ADDR : IDLE;
            end else begin
                unique case (state_q)
                    ADDR, REG, DATA: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= '0;
                            if (state_q == ADDR) begin
                                sda_oe_q <= addr_hit;
                                state_q  <= addr_hit ? ACK_ADDR : WAIT_STOP;
                            end else if (state_q == REG) begin
                                reg_q    <= shift_q;
                                sda_oe_q <= 1'b1;
                                state_q  <= ACK_REG;
                            end else begin
                                data_q   <= shift_q;
                                sda_oe_q <= 1'b1;
                                state_q  <= ACK_DATA;
                            end
                        end
                    end
                    ACK_ADDR, ACK_REG, ACK_DATA: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            if (state_q == ACK_ADDR) begin
                                state_q <= REG;
                            end else if (state_q == ACK_REG) begin
                                state_q <= DATA;
                            end else begin
                                data_out_q <= {reg_q, data_q};
                                valid_q    <= 1'b1;
                                state_q    <= WAIT_STOP;
                            end
                        end
                    end
                    IDLE, WAIT_STOP: begin
                    end
                    default: begin
                        sda_oe_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_oe     = sda_oe_q;
    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != IDLE);

endmodule
